// File: rtl/rns_op_scheduler.sv
// Sequencer/arbiter for a shared combinational RNS datapath: stores and validates the moduli set,
// arbitrates two requesters round-robin, drives the datapath and returns one response per grant.
module rns_op_scheduler #(
    parameter int unsigned DW     = 4,
    parameter int unsigned MW     = 3,
    parameter int unsigned RW     = 7,
    parameter int unsigned SETTLE = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_valid,
    output logic            cfg_ready,
    input  logic [MW-1:0]   cfg_m1,
    input  logic [MW-1:0]   cfg_m2,
    input  logic [MW-1:0]   cfg_m3,
    output logic            cfg_ok,
    output logic            cfg_err,
    input  logic [1:0]      req_valid,
    output logic [1:0]      req_ready,
    input  logic [2*DW-1:0] req_a,
    input  logic [2*DW-1:0] req_b,
    input  logic [3:0]      req_op,
    output logic            rsp_valid,
    output logic            rsp_id,
    output logic [RW-1:0]   rsp_result,
    output logic            rsp_err,
    output logic [DW-1:0]   dp_a,
    output logic [DW-1:0]   dp_b,
    output logic [MW-1:0]   dp_m1,
    output logic [MW-1:0]   dp_m2,
    output logic [MW-1:0]   dp_m3,
    output logic [1:0]      dp_op,
    input  logic [RW-1:0]   dp_result
);
    localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [2:0] {StIdle, StCheck, StIssue, StSettle, StResp} state_e;

    state_e          state_q, state_d;
    logic [MW-1:0]   m1_q, m1_d, m2_q, m2_d, m3_q, m3_d;
    logic            cfg_ok_q, cfg_ok_d;
    logic            cfg_err_q, cfg_err_d;
    logic            rr_q, rr_d;
    logic [DW-1:0]   a_q, a_d, b_q, b_d;
    logic [1:0]      op_q, op_d;
    logic            id_q, id_d;
    logic            err_q, err_d;
    logic [RW-1:0]   result_q, result_d;
    logic [1:0]      pair_q, pair_d;
    logic [MW-1:0]   gx_q, gx_d, gy_q, gy_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [DW-1:0]   dp_a_q, dp_a_d, dp_b_q, dp_b_d;
    logic [1:0]      dp_op_q, dp_op_d;

    logic [1:0]      gnt;
    logic            gnt_id;
    logic [DW-1:0]   sel_a, sel_b;
    logic [1:0]      sel_op;
    logic            mod_small;

    always_comb begin
        state_d   = state_q;
        m1_d      = m1_q;
        m2_d      = m2_q;
        m3_d      = m3_q;
        cfg_ok_d  = cfg_ok_q;
        cfg_err_d = 1'b0;
        rr_d      = rr_q;
        a_d       = a_q;
        b_d       = b_q;
        op_d      = op_q;
        id_d      = id_q;
        err_d     = err_q;
        result_d  = result_q;
        pair_d    = pair_q;
        gx_d      = gx_q;
        gy_d      = gy_q;
        cnt_d     = cnt_q;
        dp_a_d    = dp_a_q;
        dp_b_d    = dp_b_q;
        dp_op_d   = dp_op_q;
        gnt       = 2'b00;

        // Pointer only breaks ties; a lone requester always wins.
        gnt_id    = (&req_valid) ? rr_q : req_valid[1];
        sel_a     = gnt_id ? req_a[2*DW-1:DW] : req_a[DW-1:0];
        sel_b     = gnt_id ? req_b[2*DW-1:DW] : req_b[DW-1:0];
        sel_op    = gnt_id ? req_op[3:2] : req_op[1:0];
        mod_small = (m1_q < MW'(2)) || (m2_q < MW'(2)) || (m3_q < MW'(2));

        unique case (state_q)
            StIdle: begin
                if (cfg_valid) begin
                    m1_d     = cfg_m1;
                    m2_d     = cfg_m2;
                    m3_d     = cfg_m3;
                    cfg_ok_d = 1'b0;
                    gx_d     = cfg_m1;
                    gy_d     = cfg_m2;
                    pair_d   = 2'd0;
                    state_d  = StCheck;
                end else if (|req_valid) begin
                    gnt   = gnt_id ? 2'b10 : 2'b01;
                    rr_d  = ~gnt_id;
                    a_d   = sel_a;
                    b_d   = sel_b;
                    op_d  = sel_op;
                    id_d  = gnt_id;
                    err_d = (sel_op == 2'b11) || !cfg_ok_q;
                    if (err_d) begin
                        result_d = '0;
                        state_d  = StResp;
                    end else begin
                        state_d = StIssue;
                    end
                end
            end
            StCheck: begin
                if (mod_small) begin
                    cfg_err_d = 1'b1;
                    state_d   = StIdle;
                end else if (gx_q == gy_q) begin
                    // Subtractive GCD has converged; gx_q is the gcd of the current pair.
                    if (gx_q != MW'(1)) begin
                        cfg_err_d = 1'b1;
                        state_d   = StIdle;
                    end else if (pair_q == 2'd2) begin
                        cfg_ok_d = 1'b1;
                        state_d  = StIdle;
                    end else if (pair_q == 2'd0) begin
                        pair_d = 2'd1;
                        gx_d   = m1_q;
                        gy_d   = m3_q;
                    end else begin
                        pair_d = 2'd2;
                        gx_d   = m2_q;
                        gy_d   = m3_q;
                    end
                end else if (gx_q > gy_q) begin
                    gx_d = gx_q - gy_q;
                end else begin
                    gy_d = gy_q - gx_q;
                end
            end
            StIssue: begin
                dp_a_d  = a_q;
                dp_b_d  = b_q;
                dp_op_d = op_q;
                cnt_d   = CW'(SETTLE - 1);
                state_d = StSettle;
            end
            StSettle: begin
                if (cnt_q == '0) begin
                    result_d = dp_result;
                    state_d  = StResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            m1_q      <= '0;
            m2_q      <= '0;
            m3_q      <= '0;
            cfg_ok_q  <= 1'b0;
            cfg_err_q <= 1'b0;
            rr_q      <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            op_q      <= '0;
            id_q      <= 1'b0;
            err_q     <= 1'b0;
            result_q  <= '0;
            pair_q    <= '0;
            gx_q      <= '0;
            gy_q      <= '0;
            cnt_q     <= '0;
            dp_a_q    <= '0;
            dp_b_q    <= '0;
            dp_op_q   <= '0;
        end else begin
            state_q   <= state_d;
            m1_q      <= m1_d;
            m2_q      <= m2_d;
            m3_q      <= m3_d;
            cfg_ok_q  <= cfg_ok_d;
            cfg_err_q <= cfg_err_d;
            rr_q      <= rr_d;
            a_q       <= a_d;
            b_q       <= b_d;
            op_q      <= op_d;
            id_q      <= id_d;
            err_q     <= err_d;
            result_q  <= result_d;
            pair_q    <= pair_d;
            gx_q      <= gx_d;
            gy_q      <= gy_d;
            cnt_q     <= cnt_d;
            dp_a_q    <= dp_a_d;
            dp_b_q    <= dp_b_d;
            dp_op_q   <= dp_op_d;
        end
    end

    assign cfg_ready  = (state_q == StIdle);
    assign cfg_ok     = cfg_ok_q;
    assign cfg_err    = cfg_err_q;
    assign req_ready  = gnt;
    assign rsp_valid  = (state_q == StResp);
    assign rsp_id     = id_q;
    assign rsp_result = result_q;
    assign rsp_err    = err_q;
    assign dp_a       = dp_a_q;
    assign dp_b       = dp_b_q;
    assign dp_op      = dp_op_q;
    assign dp_m1      = m1_q;
    assign dp_m2      = m2_q;
    assign dp_m3      = m3_q;

endmodule

// File: tb/tb_rns_op_scheduler.sv
// Bench for rns_op_scheduler: behavioural RNS datapath, grant-time scoreboard, scenario tasks.
module tb_rns_op_scheduler;
    localparam int DW = 4, MW = 3, RW = 7, SETTLE = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cfg_valid = 1'b0;
    logic            cfg_ready;
    logic [MW-1:0]   cfg_m1 = '0, cfg_m2 = '0, cfg_m3 = '0;
    logic            cfg_ok, cfg_err;
    logic [1:0]      req_valid = '0;
    logic [1:0]      req_ready;
    logic [2*DW-1:0] req_a = '0, req_b = '0;
    logic [3:0]      req_op = '0;
    logic            rsp_valid, rsp_id, rsp_err;
    logic [RW-1:0]   rsp_result;
    logic [DW-1:0]   dp_a, dp_b;
    logic [MW-1:0]   dp_m1, dp_m2, dp_m3;
    logic [1:0]      dp_op;
    logic [RW-1:0]   dp_result;

    rns_op_scheduler #(.DW(DW), .MW(MW), .RW(RW), .SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_m1(cfg_m1), .cfg_m2(cfg_m2), .cfg_m3(cfg_m3),
        .cfg_ok(cfg_ok), .cfg_err(cfg_err),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result), .rsp_err(rsp_err),
        .dp_a(dp_a), .dp_b(dp_b), .dp_m1(dp_m1), .dp_m2(dp_m2), .dp_m3(dp_m3),
        .dp_op(dp_op), .dp_result(dp_result)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    always @(posedge clk) cyc++;

    function automatic logic [RW-1:0] calc(int a, int b, int op, int m1, int m2, int m3);
        int mm;
        int r;
        mm = m1 * m2 * m3;
        if (mm == 0) return '0;
        case (op)
            0:       r = (a + b) % mm;
            1:       r = (((a - b) % mm) + mm) % mm;
            2:       r = (a * b) % mm;
            default: r = 0;
        endcase
        return RW'(r);
    endfunction

    // Behavioural combinational datapath.
    always_comb dp_result = calc(int'(dp_a), int'(dp_b), int'(dp_op),
                                 int'(dp_m1), int'(dp_m2), int'(dp_m3));

    typedef struct {
        logic          id;
        logic [RW-1:0] res;
        logic          err;
        int            gcyc;
    } exp_t;

    exp_t          sbq[$];
    bit            gids[$];
    int            mcfg_ok = 0;
    int            mm1 = 0, mm2 = 0, mm3 = 0;
    logic [RW-1:0] last_res;
    logic          last_err;

    always @(negedge clk) begin
        exp_t       e;
        logic       gid;
        logic [1:0] gop;
        int         ga, gb, lat;
        if (!rst_n) begin
            sbq.delete();
        end else begin
            if (req_ready != 2'b00) begin
                gid   = req_ready[1];
                gop   = gid ? req_op[3:2] : req_op[1:0];
                ga    = gid ? int'(req_a[2*DW-1:DW]) : int'(req_a[DW-1:0]);
                gb    = gid ? int'(req_b[2*DW-1:DW]) : int'(req_b[DW-1:0]);
                e.id  = gid;
                e.err = (gop == 2'b11) || (mcfg_ok == 0);
                e.res = e.err ? '0 : calc(ga, gb, int'(gop), mm1, mm2, mm3);
                e.gcyc = cyc;
                sbq.push_back(e);
                gids.push_back(gid);
            end
            if (rsp_valid) begin
                last_res = rsp_result;
                last_err = rsp_err;
                n_checks++;
                if (sbq.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_rsp: rsp_valid with no outstanding grant (id=%0d res=%0d)",
                             rsp_id, rsp_result);
                end else begin
                    e   = sbq.pop_front();
                    lat = e.err ? 1 : SETTLE + 2;
                    if ({rsp_id, rsp_result, rsp_err} !== {e.id, e.res, e.err}
                        || (cyc - e.gcyc) != lat) begin
                        n_fail++;
                        $display("FAIL rsp: got id=%0d res=%0d err=%0d lat=%0d, want id=%0d res=%0d err=%0d lat=%0d",
                                 rsp_id, rsp_result, rsp_err, cyc - e.gcyc, e.id, e.res, e.err, lat);
                    end
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(bit id, int a, int b, int op);
        if (id) begin
            req_a[2*DW-1:DW] = DW'(a);
            req_b[2*DW-1:DW] = DW'(b);
            req_op[3:2]      = 2'(op);
        end else begin
            req_a[DW-1:0] = DW'(a);
            req_b[DW-1:0] = DW'(b);
            req_op[1:0]   = 2'(op);
        end
    endtask

    task automatic wait_drain(string nm);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 30) begin
            @(negedge clk);
            n++;
        end
        #1;
        n_checks++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL %s_timeout: %0d responses outstanding, want 0", nm, sbq.size());
            sbq.delete();
        end
        step();
    endtask

    task automatic do_cfg(int a, int b, int c, bit exp_ok, string nm);
        int n;
        bit saw_err;
        cfg_m1 = MW'(a);
        cfg_m2 = MW'(b);
        cfg_m3 = MW'(c);
        cfg_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cfg_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        step();
        cfg_valid = 1'b0;
        mm1 = a; mm2 = b; mm3 = c;
        mcfg_ok = 0;
        n = 0;
        saw_err = 1'b0;
        do begin
            @(negedge clk);
            n++;
            saw_err |= cfg_err;
        end while (!cfg_ready && n < 40);
        n_checks++;
        if (!cfg_ready || n > 25) begin
            n_fail++;
            $display("FAIL %s_check_len: ready=%0d after %0d cycles, want ready within 25", nm,
                     cfg_ready, n);
        end
        n_checks++;
        if (cfg_ok !== exp_ok || saw_err !== !exp_ok) begin
            n_fail++;
            $display("FAIL %s_result: cfg_ok=%0d cfg_err_seen=%0d, want cfg_ok=%0d cfg_err_seen=%0d",
                     nm, cfg_ok, saw_err, exp_ok, !exp_ok);
        end
        n_checks++;
        if ({dp_m1, dp_m2, dp_m3} !== {MW'(a), MW'(b), MW'(c)}) begin
            n_fail++;
            $display("FAIL %s_dp_m: got %0d,%0d,%0d want %0d,%0d,%0d", nm, dp_m1, dp_m2, dp_m3,
                     a, b, c);
        end
        @(negedge clk);
        n_checks++;
        if (cfg_err !== 1'b0) begin
            n_fail++;
            $display("FAIL %s_err_pulse: cfg_err=%0d one cycle later, want 0", nm, cfg_err);
        end
        mcfg_ok = exp_ok;
        step();
    endtask

    task automatic do_req(bit id, int a, int b, int op, string nm);
        int n;
        set_req(id, a, b, op);
        req_valid[id] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready[id] && n < 50) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (!req_ready[id]) begin
            n_fail++;
            $display("FAIL %s_grant_timeout: req_ready=%b, want bit %0d", nm, req_ready, id);
        end
        step();
        req_valid[id] = 1'b0;
        wait_drain(nm);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({cfg_ok, cfg_err, req_ready, rsp_valid, rsp_id, rsp_err} !== 7'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl: ok=%0d err=%0d rdy=%b rv=%0d id=%0d rerr=%0d, want all 0",
                     cfg_ok, cfg_err, req_ready, rsp_valid, rsp_id, rsp_err);
        end
        n_checks++;
        if ({rsp_result, dp_a, dp_b, dp_m1, dp_m2, dp_m3, dp_op} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: res=%0d a=%0d b=%0d m=%0d,%0d,%0d op=%0d, want all 0",
                     rsp_result, dp_a, dp_b, dp_m1, dp_m2, dp_m3, dp_op);
        end
        n_checks++;
        if (cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_cfg_ready: got %0d want 1", cfg_ready);
        end
        step();
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_no_cfg();
        do_req(1'b0, 9, 6, 0, "no_cfg");
        n_checks++;
        if (last_err !== 1'b1 || last_res !== '0 || dp_a !== '0) begin
            n_fail++;
            $display("FAIL no_cfg_err: err=%0d res=%0d dp_a=%0d, want err=1 res=0 dp_a=0",
                     last_err, last_res, dp_a);
        end
    endtask

    task automatic test_cfg();
        do_cfg(2, 4, 5, 1'b0, "cfg_245");
        do_cfg(1, 4, 5, 1'b0, "cfg_small");
        do_cfg(5, 7, 5, 1'b0, "cfg_pair13");
        do_cfg(7, 6, 5, 1'b1, "cfg_765");
        do_cfg(3, 4, 5, 1'b1, "cfg_345");
    endtask

    task automatic test_ops();
        logic [DW-1:0] pa, pb;
        logic [1:0]    pop;
        do_req(1'b0, 9, 6, 0, "add");
        n_checks++;
        if (last_res !== RW'(15) || last_err !== 1'b0) begin
            n_fail++;
            $display("FAIL add_val: got %0d err=%0d want 15 err=0", last_res, last_err);
        end
        do_req(1'b0, 9, 6, 2, "mul");
        n_checks++;
        if (last_res !== RW'(54)) begin
            n_fail++;
            $display("FAIL mul_val: got %0d want 54", last_res);
        end
        do_req(1'b0, 9, 6, 1, "sub");
        n_checks++;
        if (last_res !== RW'(3)) begin
            n_fail++;
            $display("FAIL sub_val: got %0d want 3", last_res);
        end
        do_req(1'b0, 2, 7, 1, "sub_wrap");
        n_checks++;
        if (last_res !== RW'(55)) begin
            n_fail++;
            $display("FAIL sub_wrap_val: got %0d want 55", last_res);
        end
        pa = dp_a; pb = dp_b; pop = dp_op;
        do_req(1'b0, 9, 6, 3, "op11");
        n_checks++;
        if (last_err !== 1'b1 || last_res !== '0 || {dp_a, dp_b, dp_op} !== {pa, pb, pop}) begin
            n_fail++;
            $display("FAIL op11: err=%0d res=%0d dp=%0d/%0d/%0d, want err=1 res=0 dp=%0d/%0d/%0d",
                     last_err, last_res, dp_a, dp_b, dp_op, pa, pb, pop);
        end
        do_req(1'b1, 13, 11, 2, "req1_mul");
        n_checks++;
        if (last_res !== RW'(23)) begin
            n_fail++;
            $display("FAIL req1_mul_val: got %0d want 23", last_res);
        end
    endtask

    task automatic test_back_to_back();
        int  ng, n;
        bit  gid;
        bit  got[$];
        set_req(1'b0, 9, 6, 0);
        set_req(1'b1, 2, 3, 2);
        req_valid = 2'b11;
        ng = 0;
        n  = 0;
        while (ng < 4 && n < 100) begin
            @(negedge clk);
            n++;
            if (req_ready != 2'b00) begin
                gid = req_ready[1];
                got.push_back(gid);
                ng++;
                step();
                set_req(gid, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                        int'($urandom_range(0, 3)));
                if (ng == 4) req_valid = 2'b00;
            end
        end
        req_valid = 2'b00;
        wait_drain("b2b");
        n_checks++;
        if (got.size() != 4 || got[0] != 1'b0 || got[1] != 1'b1 || got[2] != 1'b0
            || got[3] != 1'b1) begin
            n_fail++;
            $display("FAIL b2b_order: got %0d grants %p, want 0,1,0,1", got.size(), got);
        end
    endtask

    task automatic test_cfg_priority();
        int n;
        set_req(1'b0, 4, 5, 0);
        req_valid[0] = 1'b1;
        cfg_m1 = 3'd3; cfg_m2 = 3'd4; cfg_m3 = 3'd5;
        cfg_valid = 1'b1;
        @(negedge clk);
        n_checks++;
        if (req_ready !== 2'b00 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_grant: req_ready=%b cfg_ready=%0d, want 00 and 1", req_ready,
                     cfg_ready);
        end
        step();
        cfg_valid = 1'b0;
        mcfg_ok = 1;
        @(negedge clk);
        n_checks++;
        if (cfg_ready !== 1'b0 || req_ready !== 2'b00) begin
            n_fail++;
            $display("FAIL prio_check: cfg_ready=%0d req_ready=%b, want 0 and 00", cfg_ready,
                     req_ready);
        end
        n = 0;
        while (!req_ready[0] && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (!req_ready[0] || cfg_ok !== 1'b1) begin
            n_fail++;
            $display("FAIL prio_served: req_ready=%b cfg_ok=%0d, want bit0 and 1", req_ready,
                     cfg_ok);
        end
        step();
        req_valid = 2'b00;
        wait_drain("prio");
        n_checks++;
        if (last_res !== RW'(9) || last_err !== 1'b0) begin
            n_fail++;
            $display("FAIL prio_val: got %0d err=%0d want 9 err=0", last_res, last_err);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        bit saw;
        set_req(1'b0, 5, 7, 2);
        req_valid[0] = 1'b1;
        n = 0;
        @(negedge clk);
        while (!req_ready[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        step();
        req_valid = 2'b00;
        step();
        rst_n = 1'b0;
        mcfg_ok = 0;
        #1;
        n_checks++;
        if ({rsp_valid, cfg_ok, rsp_result, dp_a, dp_b, dp_op, dp_m1, dp_m2, dp_m3} !== '0) begin
            n_fail++;
            $display("FAIL midrst_outs: rv=%0d ok=%0d res=%0d dp=%0d/%0d/%0d m=%0d,%0d,%0d, want 0",
                     rsp_valid, cfg_ok, rsp_result, dp_a, dp_b, dp_op, dp_m1, dp_m2, dp_m3);
        end
        saw = 1'b0;
        repeat (3) begin
            @(negedge clk);
            saw |= rsp_valid;
        end
        step();
        rst_n = 1'b1;
        repeat (6) begin
            @(negedge clk);
            saw |= rsp_valid;
        end
        n_checks++;
        if (saw || cfg_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL midrst_norsp: rsp_valid_seen=%0d cfg_ok=%0d, want 0 and 0", saw, cfg_ok);
        end
        step();
        do_cfg(3, 4, 5, 1'b1, "recfg");
        do_req(1'b0, 5, 7, 0, "after_rst");
        n_checks++;
        if (last_res !== RW'(12) || last_err !== 1'b0) begin
            n_fail++;
            $display("FAIL after_rst_val: got %0d err=%0d want 12 err=0", last_res, last_err);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_no_cfg();
        test_cfg();
        test_ops();
        test_back_to_back();
        test_cfg_priority();
        test_reset_mid();
        n_checks++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL final_drain: %0d responses outstanding, want 0", sbq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
